bsg_murn_block_adapter: RTL and testbench

Block-side endpoint of a murn switch port: presents a murn block interface to the switch and a bsg valid/yumi plus valid/ready interface to a local client. Inbound words (switch to block, valid->retry) are buffered in a 2-entry FIFO and delivered on valid/yumi. Outbound words (client to block to switch, retry->valid) are buffered in a 2-entry FIFO so that the client-facing ready is registered and independent of the switch retry. Instantiate one per node, between a murn switch port and a client such as an ALU or fsb node.

---
 rtl/bsg_murn_block_adapter.sv | 110 +++++++++++
 tb/tb_bsg_murn_block_adapter.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_murn_block_adapter.sv
// Block-side endpoint of a murn switch port.
// Two independent 2-entry FIFOs bridge the switch and a local client.

module bsg_murn_fifo2 #(
    parameter int width_p = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enq,
    input  logic               deq,
    input  logic [width_p-1:0] wdata,
    output logic [width_p-1:0] rdata,
    output logic               full,
    output logic               empty
);

    logic [width_p-1:0] mem [2];
    logic               rd_ptr;
    logic               wr_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (enq) wr_ptr <= ~wr_ptr;
            if (deq) rd_ptr <= ~rd_ptr;
            if (enq && !deq) begin
                empty <= 1'b0;
                full  <= ((wr_ptr + 1'b1) == rd_ptr);
            end else if (deq && !enq) begin
                full  <= 1'b0;
                empty <= ((rd_ptr + 1'b1) == wr_ptr);
            end
        end
    end

    // storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (enq) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

module bsg_murn_block_adapter #(
    parameter int ring_width_p = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    switch_2_blockValid,
    output logic                    switch_2_blockRetry,
    input  logic [ring_width_p-1:0] switch_2_blockData,
    output logic                    v_o,
    output logic [ring_width_p-1:0] data_o,
    input  logic                    yumi_i,
    input  logic                    v_i,
    output logic                    ready_o,
    input  logic [ring_width_p-1:0] data_i,
    output logic                    block_2_switchValid,
    input  logic                    block_2_switchRetry,
    output logic [ring_width_p-1:0] block_2_switchData
);

    logic in_full;
    logic in_empty;
    logic in_enq;
    logic out_full;
    logic out_empty;
    logic out_enq;

    // reset masks every handshake so nothing is accepted or delivered
    assign switch_2_blockRetry = switch_2_blockValid & (in_full | reset_i);
    assign in_enq = switch_2_blockValid & ~in_full & ~reset_i;
    assign v_o = ~in_empty & ~reset_i;

    bsg_murn_fifo2 #(.width_p(ring_width_p)) in_fifo (
        .clk   (clk_i),
        .reset (reset_i),
        .enq   (in_enq),
        .deq   (yumi_i),
        .wdata (switch_2_blockData),
        .rdata (data_o),
        .full  (in_full),
        .empty (in_empty)
    );

    assign ready_o = ~out_full & ~reset_i;
    assign out_enq = v_i & ready_o;
    assign block_2_switchValid = ~out_empty & ~block_2_switchRetry & ~reset_i;

    bsg_murn_fifo2 #(.width_p(ring_width_p)) out_fifo (
        .clk   (clk_i),
        .reset (reset_i),
        .enq   (out_enq),
        .deq   (block_2_switchValid),
        .wdata (data_i),
        .rdata (block_2_switchData),
        .full  (out_full),
        .empty (out_empty)
    );

    yumi_legal: assert property (
        @(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o)
    );

endmodule

// File: tb/tb_bsg_murn_block_adapter.sv
// Bench for bsg_murn_block_adapter: queue scoreboard per direction
// checked every cycle, plus directed scenario tasks.

module tb_bsg_murn_block_adapter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_i;
    logic         switch_2_blockValid;
    logic         switch_2_blockRetry;
    logic [W-1:0] switch_2_blockData;
    logic         v_o;
    logic [W-1:0] data_o;
    logic         yumi_i;
    logic         v_i;
    logic         ready_o;
    logic [W-1:0] data_i;
    logic         block_2_switchValid;
    logic         block_2_switchRetry;
    logic [W-1:0] block_2_switchData;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] in_q[$];
    logic [W-1:0] out_q[$];
    logic [W-1:0] in_seen[$];
    logic [W-1:0] out_seen[$];
    bit in_acc;
    bit out_acc;

    always #5 clk = ~clk;

    bsg_murn_block_adapter #(.ring_width_p(W)) dut (
        .clk_i               (clk),
        .reset_i             (reset_i),
        .switch_2_blockValid (switch_2_blockValid),
        .switch_2_blockRetry (switch_2_blockRetry),
        .switch_2_blockData  (switch_2_blockData),
        .v_o                 (v_o),
        .data_o              (data_o),
        .yumi_i              (yumi_i),
        .v_i                 (v_i),
        .ready_o             (ready_o),
        .data_i              (data_i),
        .block_2_switchValid (block_2_switchValid),
        .block_2_switchRetry (block_2_switchRetry),
        .block_2_switchData  (block_2_switchData)
    );

    // One clock: compare outputs against the queue model mid-cycle,
    // then account for the transfers that happen at the next edge.
    task automatic cycle();
        @(negedge clk);
        if (reset_i) begin
            checks++;
            if (switch_2_blockRetry !== switch_2_blockValid) begin
                errors++;
                $display("FAIL rst_retry got %b exp %b",
                         switch_2_blockRetry, switch_2_blockValid);
            end
            checks++;
            if ({ready_o, v_o, block_2_switchValid} !== 3'b000) begin
                errors++;
                $display("FAIL rst_outs got %b%b%b exp 000",
                         ready_o, v_o, block_2_switchValid);
            end
            in_q.delete();
            out_q.delete();
            in_acc = 1'b0;
            out_acc = 1'b0;
        end else begin
            checks++;
            if (switch_2_blockRetry !==
                (switch_2_blockValid && in_q.size() == 2)) begin
                errors++;
                $display("FAIL retry got %b exp %b", switch_2_blockRetry,
                         switch_2_blockValid && in_q.size() == 2);
            end
            checks++;
            if (v_o !== (in_q.size() != 0)) begin
                errors++;
                $display("FAIL v_o got %b exp %b", v_o, in_q.size() != 0);
            end
            if (in_q.size() != 0) begin
                checks++;
                if (data_o !== in_q[0]) begin
                    errors++;
                    $display("FAIL data_o got %h exp %h", data_o, in_q[0]);
                end
            end
            checks++;
            if (ready_o !== (out_q.size() < 2)) begin
                errors++;
                $display("FAIL ready_o got %b exp %b",
                         ready_o, out_q.size() < 2);
            end
            checks++;
            if (block_2_switchValid !==
                (out_q.size() != 0 && !block_2_switchRetry)) begin
                errors++;
                $display("FAIL out_valid got %b exp %b", block_2_switchValid,
                         out_q.size() != 0 && !block_2_switchRetry);
            end
            if (out_q.size() != 0) begin
                checks++;
                if (block_2_switchData !== out_q[0]) begin
                    errors++;
                    $display("FAIL out_data got %h exp %h",
                             block_2_switchData, out_q[0]);
                end
            end
            in_acc = switch_2_blockValid && in_q.size() < 2;
            out_acc = v_i && out_q.size() < 2;
            if (yumi_i && in_q.size() != 0)
                in_seen.push_back(in_q.pop_front());
            if (out_q.size() != 0 && !block_2_switchRetry)
                out_seen.push_back(out_q.pop_front());
            if (in_acc) in_q.push_back(switch_2_blockData);
            if (out_acc) out_q.push_back(data_i);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        switch_2_blockValid = 1'b0;
        v_i = 1'b0;
        block_2_switchRetry = 1'b0;
        n = 0;
        while ((in_q.size() != 0 || out_q.size() != 0) && n < 50) begin
            yumi_i = v_o;
            cycle();
            n++;
        end
        yumi_i = 1'b0;
        checks++;
        if (in_q.size() != 0 || out_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d/%0d exp 0/0",
                     in_q.size(), out_q.size());
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        switch_2_blockValid = 1'b1;
        cycle();
        cycle();
        reset_i = 1'b0;
        #1;
        checks++;
        if (switch_2_blockRetry !== 1'b0) begin
            errors++;
            $display("FAIL post_rst_retry got %b exp 0", switch_2_blockRetry);
        end
        switch_2_blockValid = 1'b0;
        checks++;
        if ({ready_o, v_o, block_2_switchValid} !== 3'b100) begin
            errors++;
            $display("FAIL post_rst_outs got %b%b%b exp 100",
                     ready_o, v_o, block_2_switchValid);
        end
        cycle();
    endtask

    task automatic test_inbound_stream();
        in_seen.delete();
        for (int i = 0; i < 5; i++) begin
            switch_2_blockValid = 1'b1;
            switch_2_blockData = W'(i + 1);
            yumi_i = v_o;
            #1;
            checks++;
            if (v_o !== (i != 0)) begin
                errors++;
                $display("FAIL stream_v_o[%0d] got %b exp %b", i, v_o, i != 0);
            end
            checks++;
            if (switch_2_blockRetry !== 1'b0) begin
                errors++;
                $display("FAIL stream_retry[%0d] got %b exp 0",
                         i, switch_2_blockRetry);
            end
            cycle();
        end
        drain();
        checks++;
        if (in_seen.size() != 5) begin
            errors++;
            $display("FAIL stream_count got %0d exp 5", in_seen.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (in_seen[i] !== W'(i + 1)) begin
                    errors++;
                    $display("FAIL stream_order[%0d] got %h exp %h",
                             i, in_seen[i], W'(i + 1));
                end
            end
        end
    endtask

    task automatic check_retry(input string name, input logic exp);
        #1;
        checks++;
        if (switch_2_blockRetry !== exp) begin
            errors++;
            $display("FAIL %s got %b exp %b", name, switch_2_blockRetry, exp);
        end
    endtask

    task automatic test_inbound_backpressure();
        logic [W-1:0] exp[3];
        exp[0] = 8'h0A;
        exp[1] = 8'h0B;
        exp[2] = 8'h0C;
        in_seen.delete();
        yumi_i = 1'b0;
        switch_2_blockValid = 1'b1;
        switch_2_blockData = 8'h0A;
        check_retry("bp_retry_a", 1'b0);
        cycle();
        switch_2_blockData = 8'h0B;
        check_retry("bp_retry_b", 1'b0);
        cycle();
        switch_2_blockData = 8'h0C;
        check_retry("bp_retry_c", 1'b1);
        cycle();
        check_retry("bp_retry_c_hold", 1'b1);
        cycle();
        yumi_i = 1'b1;
        check_retry("bp_retry_c_deq", 1'b1);
        cycle();
        yumi_i = 1'b0;
        check_retry("bp_retry_c_acc", 1'b0);
        cycle();
        drain();
        checks++;
        if (in_seen.size() != 3) begin
            errors++;
            $display("FAIL bp_count got %0d exp 3", in_seen.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (in_seen[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL bp_order[%0d] got %h exp %h",
                             i, in_seen[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_outbound_retry();
        out_seen.delete();
        block_2_switchRetry = 1'b1;
        v_i = 1'b1;
        data_i = 8'h11;
        cycle();
        data_i = 8'h22;
        cycle();
        v_i = 1'b0;
        checks++;
        if (ready_o !== 1'b0 || block_2_switchValid !== 1'b0) begin
            errors++;
            $display("FAIL or_full got %b%b exp 00",
                     ready_o, block_2_switchValid);
        end
        cycle();
        block_2_switchRetry = 1'b0;
        #1;
        checks++;
        if (block_2_switchValid !== 1'b1 || block_2_switchData !== 8'h11) begin
            errors++;
            $display("FAIL or_first got %b/%h exp 1/11",
                     block_2_switchValid, block_2_switchData);
        end
        cycle();
        checks++;
        if (ready_o !== 1'b1 || block_2_switchData !== 8'h22) begin
            errors++;
            $display("FAIL or_second got %b/%h exp 1/22",
                     ready_o, block_2_switchData);
        end
        drain();
        checks++;
        if (out_seen.size() != 2) begin
            errors++;
            $display("FAIL or_count got %0d exp 2", out_seen.size());
        end
    endtask

    task automatic test_outbound_toggle();
        logic [W-1:0] sent[$];
        int n;
        int cnt;
        out_seen.delete();
        cnt = 0;
        n = 0;
        v_i = 1'b0;
        while ((cnt < 200 || out_q.size() != 0) && n < 3000) begin
            if (!v_i || out_acc) begin
                v_i = (cnt < 200);
                data_i = W'(cnt * 7 + 3);
            end
            block_2_switchRetry = 1'($urandom_range(0, 1));
            cycle();
            if (out_acc) begin
                sent.push_back(data_i);
                cnt++;
                v_i = 1'b0;
            end
            n++;
        end
        drain();
        checks++;
        if (out_seen.size() != 200 || sent.size() != 200) begin
            errors++;
            $display("FAIL toggle_count got %0d/%0d exp 200",
                     out_seen.size(), sent.size());
        end else begin
            for (int i = 0; i < 200; i++) begin
                checks++;
                if (out_seen[i] !== sent[i]) begin
                    errors++;
                    $display("FAIL toggle_seq[%0d] got %h exp %h",
                             i, out_seen[i], sent[i]);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        yumi_i = 1'b0;
        block_2_switchRetry = 1'b1;
        switch_2_blockValid = 1'b1;
        v_i = 1'b1;
        switch_2_blockData = 8'h55;
        data_i = 8'h66;
        cycle();
        switch_2_blockData = 8'h56;
        data_i = 8'h67;
        cycle();
        v_i = 1'b0;
        #1;
        checks++;
        if (switch_2_blockRetry !== 1'b1 || ready_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_full got %b%b exp 10",
                     switch_2_blockRetry, ready_o);
        end
        reset_i = 1'b1;
        cycle();
        reset_i = 1'b0;
        switch_2_blockValid = 1'b0;
        block_2_switchRetry = 1'b0;
        #1;
        checks++;
        if ({ready_o, v_o, block_2_switchValid} !== 3'b100) begin
            errors++;
            $display("FAIL mid_after got %b%b%b exp 100",
                     ready_o, v_o, block_2_switchValid);
        end
        in_seen.delete();
        out_seen.delete();
        for (int i = 0; i < 4; i++) begin
            yumi_i = v_o;
            cycle();
        end
        yumi_i = 1'b0;
        checks++;
        if (in_seen.size() != 0 || out_seen.size() != 0) begin
            errors++;
            $display("FAIL mid_ghost got %0d/%0d exp 0/0",
                     in_seen.size(), out_seen.size());
        end
    endtask

    task automatic test_concurrent();
        int sent_in;
        int sent_out;
        in_seen.delete();
        out_seen.delete();
        sent_in = 0;
        sent_out = 0;
        switch_2_blockValid = 1'b0;
        v_i = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            if (!switch_2_blockValid || in_acc) begin
                switch_2_blockValid = 1'($urandom_range(0, 1));
                switch_2_blockData = W'($urandom);
            end
            if (!v_i || out_acc) begin
                v_i = 1'($urandom_range(0, 1));
                data_i = W'($urandom);
            end
            yumi_i = v_o & 1'($urandom_range(0, 1));
            block_2_switchRetry = ($urandom_range(0, 3) == 0);
            cycle();
            if (in_acc) sent_in++;
            if (out_acc) sent_out++;
        end
        drain();
        checks++;
        if (in_seen.size() != sent_in || out_seen.size() != sent_out) begin
            errors++;
            $display("FAIL conc_count got %0d/%0d exp %0d/%0d",
                     in_seen.size(), out_seen.size(), sent_in, sent_out);
        end
    endtask

    initial begin
        reset_i = 1'b1;
        switch_2_blockValid = 1'b0;
        switch_2_blockData = '0;
        yumi_i = 1'b0;
        v_i = 1'b0;
        data_i = '0;
        block_2_switchRetry = 1'b0;
        in_acc = 1'b0;
        out_acc = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_inbound_stream();
        test_inbound_backpressure();
        test_outbound_retry();
        test_outbound_toggle();
        test_reset_midflight();
        test_concurrent();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
